mem_data_port: RTL and testbench
================================

Name: mem_data_port

Overview:
- Memory-side endpoint of the datapath bus: the sink that captures bus values into MAR/MDR and the source that supplies the MDR value back to the bus (BusMuxIn_MDR).
- Runs a req/ack handshake with data memory for single-word reads and writes, with a wait-state timeout.
- Sits between the bus/control unit and the RAM wrapper.

Parameters:
- ADDR_W, 9, memory address width (MAR holds BusMuxOut[ADDR_W-1:0]).
- DATA_W, 32, bus and memory data width.
- TIMEOUT, 16, maximum cycles spent waiting for mem_ack; 0 disables the timeout.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- BusMuxOut  in  DATA_W  bus value.
- MARin  in  1  load MAR from the bus.
- MDRin  in  1  load MDR from the bus.
- start_read  in  1  one-cycle pulse: read mem[MAR] into MDR.
- start_write  in  1  one-cycle pulse: write MDR to mem[MAR].
- BusMuxIn_MDR  out  DATA_W  MDR contents, to the bus mux.
- busy  out  1  transaction in progress (states RD, WR, FIN).
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout pulse, coincident with done.
- mem_addr  out  ADDR_W  equals MAR.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_wdata  out  DATA_W  equals MDR.
- mem_rdata  in  DATA_W  read data; valid when mem_ack is high.
- mem_ack  in  1  memory completion; sampled only in RD/WR.

Behaviour:
- Reset (asynchronous, reset_n=0): MAR=0, MDR=0, state=IDLE, wait counter=0, err_flag=0. All outputs read 0 while reset is held, including mid-transaction. mem_req drops immediately with no completion pulse.
- States: IDLE, RD, WR, FIN. Outputs are Moore-decoded from state:
  - mem_req = (RD|WR)
  - mem_we = WR
  - busy = (state != IDLE)
  - done = FIN
  - err = FIN & err_flag
- MAR/MDR loads, in IDLE only:
  - MARin: MAR <= BusMuxOut[ADDR_W-1:0].
  - MDRin: MDR <= BusMuxOut.
  - Both may be asserted in the same cycle.
  - While busy, MARin and MDRin are ignored so the address and write data stay stable.
- IDLE transitions:
  - start_read -> RD.
  - start_write -> WR.
  - Both asserted together: read wins, the write is dropped.
  - Loads and a start in the same cycle: the loads take effect and the transaction uses the new MAR/MDR.
  - start pulses outside IDLE are ignored; there is no queuing.
- Entering RD or WR clears the wait counter and err_flag.
- RD/WR, each cycle:
  - mem_ack=1: in RD, MDR <= mem_rdata; go to FIN.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: set err_flag; go to FIN. MDR is unchanged.
  - Else: counter += 1. The counter is $clog2(TIMEOUT+1) bits wide and never wraps.
- FIN -> IDLE unconditionally. FIN lasts exactly one cycle.
- Latency: start sampled at edge 0; mem_req high in cycle 1. With ack in cycle 1, done is high in cycle 2 and busy falls in cycle 3. Each added wait state adds one cycle.
- mem_ack while in IDLE or FIN is ignored.
- BusMuxIn_MDR always reflects MDR, including during a transaction.

Decomposition:
- Shared package mem_pkg:
  - State encoding enum (IDLE=2'd0, RD=2'd1, WR=2'd2, FIN=2'd3).
  - Default ADDR_W/DATA_W constants, shared with the RAM wrapper.
- One natural sub-module, wait_timer: the TIMEOUT counter with clear, enable and expired outputs.
- MAR/MDR and the FSM stay in mem_data_port.

Test Plan:
- Reset mid-read: assert reset_n=0 while in RD -> mem_req, busy and done all 0 in the same cycle; after release, state is IDLE and MDR=0.
- Load and read: BusMuxOut=0x0000_0055 with MARin, then start_read; memory acks in cycle 1 with rdata=0xDEAD_BEEF -> mem_addr=0x055, done in cycle 2, BusMuxIn_MDR=0xDEAD_BEEF, err=0.
- Write with 3 wait states: MDRin with 0x1234_5678, then start_write -> mem_we=1 and mem_wdata=0x1234_5678 for 4 cycles; done one cycle after the ack.
- Timeout: TIMEOUT=16, mem_ack never asserted -> mem_req high for exactly 16 cycles, then done=err=1 for one cycle, MDR unchanged.
- Simultaneous and busy events: start_read with start_write -> read only (mem_we=0). MARin=0x1FF during RD -> mem_addr unchanged. start_write during RD -> ignored.
- Stray ack: mem_ack=1 in IDLE -> no done and MDR unchanged; a subsequent read completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default widths for the data-memory port and RAM wrapper.
package mem_pkg;

   localparam int unsigned MEM_ADDR_W = 9;
   localparam int unsigned MEM_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_FIN  = 2'd3
   } mem_state_e;

endpackage : mem_pkg

// File: rtl/mem_data_port_wait_timer.sv
// Wait-state counter for a memory transaction; flags the last allowed wait cycle.
module mem_data_port_wait_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Expiry only exists when a timeout is configured.
   assign expired_o = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   // Clear wins; otherwise count up, saturating so the counter never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_o && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : mem_data_port_wait_timer

// File: rtl/mem_data_port.sv
// Memory-side bus endpoint: MAR/MDR capture and single-word req/ack transactions.
module mem_data_port
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = MEM_ADDR_W,
   parameter int unsigned DATA_W  = MEM_DATA_W,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] BusMuxOut,
   input  logic              MARin,
   input  logic              MDRin,
   input  logic              start_read,
   input  logic              start_write,
   output logic [DATA_W-1:0] BusMuxIn_MDR,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   mem_state_e        state_q, state_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic              err_flag_q, err_flag_d;
   logic              mem_req_q, mem_we_q, busy_q, done_q, err_q;
   logic              tmr_clear, tmr_en, tmr_expired;

   mem_data_port_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk_i     (clock),
      .rst_ni    (reset_n),
      .clear_i   (tmr_clear),
      .en_i      (tmr_en),
      .expired_o (tmr_expired)
   );

   // Next state, MAR/MDR updates and timer control.
   always_comb begin
      state_d    = state_q;
      mar_d      = mar_q;
      mdr_d      = mdr_q;
      err_flag_d = err_flag_q;
      tmr_clear  = 1'b0;
      tmr_en     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (MARin) mar_d = BusMuxOut[ADDR_W-1:0];
            if (MDRin) mdr_d = BusMuxOut;
            if (start_read || start_write) begin
               // Read wins when both starts arrive together.
               state_d    = start_read ? ST_RD : ST_WR;
               tmr_clear  = 1'b1;
               err_flag_d = 1'b0;
            end
         end
         ST_RD, ST_WR: begin
            if (mem_ack) begin
               if (state_q == ST_RD) mdr_d = mem_rdata;
               state_d = ST_FIN;
            end else if (tmr_expired) begin
               err_flag_d = 1'b1;
               state_d    = ST_FIN;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, datapath registers and state-decoded outputs, registered from next state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         mar_q      <= '0;
         mdr_q      <= '0;
         err_flag_q <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mar_q      <= mar_d;
         mdr_q      <= mdr_d;
         err_flag_q <= err_flag_d;
         mem_req_q  <= (state_d == ST_RD) || (state_d == ST_WR);
         mem_we_q   <= (state_d == ST_WR);
         busy_q     <= (state_d != ST_IDLE);
         done_q     <= (state_d == ST_FIN);
         err_q      <= (state_d == ST_FIN) && err_flag_d;
      end
   end

   assign BusMuxIn_MDR = mdr_q;
   assign mem_wdata    = mdr_q;
   assign mem_addr     = mar_q;
   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;

endmodule : mem_data_port

// File: tb/tb_mem_data_port.sv
// Scoreboard bench for mem_data_port: bench-side memory responder and MAR/MDR model.
module tb_mem_data_port;

   localparam int unsigned AW = 9;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 16;

   typedef struct {
      logic [DW-1:0] mdr;
      logic          err;
      int            req_cycles;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [DW-1:0] BusMuxOut;
   logic          MARin, MDRin, start_read, start_write;
   logic [DW-1:0] BusMuxIn_MDR;
   logic          busy, done, err;
   logic [AW-1:0] mem_addr;
   logic          mem_req, mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;

   int            vectors     = 0;
   int            miscompares = 0;
   exp_t          sb_q[$];
   logic [AW-1:0] m_mar;
   logic [DW-1:0] m_mdr;

   always #5 clock = ~clock;

   mem_data_port #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .BusMuxOut    (BusMuxOut),
      .MARin        (MARin),
      .MDRin        (MDRin),
      .start_read   (start_read),
      .start_write  (start_write),
      .BusMuxIn_MDR (BusMuxIn_MDR),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .mem_addr     (mem_addr),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ack      (mem_ack)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      BusMuxOut   = '0;
      MARin       = 1'b0;
      MDRin       = 1'b0;
      start_read  = 1'b0;
      start_write = 1'b0;
      mem_ack     = 1'b0;
      mem_rdata   = '0;
   endtask

   // One transaction; waits < 0 means memory never acks. disturb pokes loads/starts while busy.
   task automatic do_txn(input bit rd, input bit wr, input bit ld_mar, input bit ld_mdr,
                         input logic [DW-1:0] bus, input int waits,
                         input logic [DW-1:0] rdata, input bit disturb);
      exp_t e, got;
      int   req_cycles;
      bit   exp_we;
      bit   hung;
      BusMuxOut   = bus;
      MARin       = ld_mar;
      MDRin       = ld_mdr;
      start_read  = rd;
      start_write = wr;
      if (ld_mar) m_mar = bus[AW-1:0];
      if (ld_mdr) m_mdr = bus;
      exp_we       = !rd && wr;
      e.err        = (waits < 0);
      e.req_cycles = (waits < 0) ? int'(TO) : waits + 1;
      e.mdr        = (rd && waits >= 0) ? rdata : m_mdr;
      sb_q.push_back(e);
      step();
      clear_inputs();
      req_cycles = 0;
      hung       = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (!mem_req) begin
            hung = 1'b0;
            break;
         end
         req_cycles++;
         vectors++;
         if (mem_we !== exp_we || mem_addr !== m_mar || mem_wdata !== m_mdr || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL req_phase cyc %0d: we=%b addr=%h wdata=%h busy=%b, want we=%b addr=%h wdata=%h busy=1",
                     req_cycles, mem_we, mem_addr, mem_wdata, busy, exp_we, m_mar, m_mdr);
         end
         if (waits >= 0 && req_cycles == waits + 1) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata;
         end
         if (disturb) begin
            BusMuxOut   = 32'hFFFF_FFFF;
            MARin       = 1'b1;
            MDRin       = 1'b1;
            start_write = 1'b1;
            start_read  = 1'b1;
         end
         step();
         clear_inputs();
      end
      vectors++;
      if (hung) begin
         miscompares++;
         $display("FAIL req_bound: mem_req still high after 40 cycles");
      end
      got = sb_q.pop_front();
      vectors++;
      if (req_cycles !== got.req_cycles) begin
         miscompares++;
         $display("FAIL req_len: got %0d cycles, want %0d", req_cycles, got.req_cycles);
      end
      vectors++;
      if (done !== 1'b1 || busy !== 1'b1 || err !== got.err || BusMuxIn_MDR !== got.mdr) begin
         miscompares++;
         $display("FAIL fin: done=%b busy=%b err=%b mdr=%h, want done=1 busy=1 err=%b mdr=%h",
                  done, busy, err, BusMuxIn_MDR, got.err, got.mdr);
      end
      m_mdr = got.mdr;
      step();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || mem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL after_fin: done=%b busy=%b err=%b req=%b, want all 0", done, busy, err, mem_req);
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      reset_n = 1'b0;
      m_mar   = '0;
      m_mdr   = '0;
      step();
      step();
      vectors++;
      if (busy !== 0 || done !== 0 || err !== 0 || mem_req !== 0 || mem_we !== 0 ||
          mem_addr !== '0 || BusMuxIn_MDR !== '0) begin
         miscompares++;
         $display("FAIL reset_vals: busy=%b done=%b err=%b req=%b we=%b addr=%h mdr=%h, want all 0",
                  busy, done, err, mem_req, mem_we, mem_addr, BusMuxIn_MDR);
      end
      #2 reset_n = 1'b1;
      step();
      // Reset in the middle of a read.
      BusMuxOut  = 32'h0000_00AA;
      MARin      = 1'b1;
      MDRin      = 1'b1;
      start_read = 1'b1;
      step();
      clear_inputs();
      vectors++;
      if (mem_req !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_rd_entry: req=%b busy=%b, want 1 1", mem_req, busy);
      end
      #1 reset_n = 1'b0;
      #1;
      vectors++;
      if (mem_req !== 0 || busy !== 0 || done !== 0 || BusMuxIn_MDR !== '0 || mem_addr !== '0) begin
         miscompares++;
         $display("FAIL mid_rd_reset: req=%b busy=%b done=%b mdr=%h addr=%h, want all 0",
                  mem_req, busy, done, BusMuxIn_MDR, mem_addr);
      end
      #1 reset_n = 1'b1;
      step();
      step();
      vectors++;
      if (busy !== 0 || done !== 0 || BusMuxIn_MDR !== '0) begin
         miscompares++;
         $display("FAIL post_reset_idle: busy=%b done=%b mdr=%h, want 0 0 0", busy, done, BusMuxIn_MDR);
      end
   endtask

   task automatic test_load_read();
      BusMuxOut = 32'h0000_0055;
      MARin     = 1'b1;
      m_mar     = 9'h055;
      step();
      clear_inputs();
      vectors++;
      if (mem_addr !== 9'h055 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL mar_load: addr=%h busy=%b, want 055 0", mem_addr, busy);
      end
      do_txn(1'b1, 1'b0, 1'b0, 1'b0, '0, 0, 32'hDEAD_BEEF, 1'b0);
   endtask

   task automatic test_write_waits();
      BusMuxOut = 32'h1234_5678;
      MDRin     = 1'b1;
      m_mdr     = 32'h1234_5678;
      step();
      clear_inputs();
      vectors++;
      if (BusMuxIn_MDR !== 32'h1234_5678) begin
         miscompares++;
         $display("FAIL mdr_load: got %h want 12345678", BusMuxIn_MDR);
      end
      do_txn(1'b0, 1'b1, 1'b0, 1'b0, '0, 3, 32'hBAD0_BAD0, 1'b0);
   endtask

   task automatic test_timeout();
      do_txn(1'b1, 1'b0, 1'b0, 1'b0, '0, -1, 32'h0, 1'b0);
   endtask

   task automatic test_busy_events();
      // Both starts together: read only, then loads/starts while busy are ignored.
      do_txn(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0123, 2, 32'hCAFE_F00D, 1'b1);
      step();
      vectors++;
      if (busy !== 1'b0 || mem_req !== 1'b0 || mem_addr !== m_mar || BusMuxIn_MDR !== m_mdr) begin
         miscompares++;
         $display("FAIL no_queue: busy=%b req=%b addr=%h mdr=%h, want 0 0 %h %h",
                  busy, mem_req, mem_addr, BusMuxIn_MDR, m_mar, m_mdr);
      end
   endtask

   task automatic test_back_to_back();
      // Loads and a start in the same cycle use the new MAR/MDR.
      do_txn(1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A5_A1C3, 1, 32'h0, 1'b0);
      do_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_01FF, 0, 32'h0F0F_1234, 1'b0);
      for (int i = 0; i < 3; i++) begin
         do_txn(1'b1, 1'b0, 1'b1, 1'b0, $urandom, int'($urandom_range(0, 5)), $urandom, 1'b0);
      end
   endtask

   task automatic test_stray_ack();
      logic [DW-1:0] keep;
      keep      = m_mdr;
      mem_ack   = 1'b1;
      mem_rdata = 32'h7777_7777;
      step();
      step();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || BusMuxIn_MDR !== keep) begin
         miscompares++;
         $display("FAIL stray_ack: done=%b busy=%b mdr=%h, want 0 0 %h", done, busy, BusMuxIn_MDR, keep);
      end
      clear_inputs();
      do_txn(1'b1, 1'b0, 1'b0, 1'b0, '0, 1, 32'h3141_5926, 1'b0);
   endtask

   initial begin
      test_reset();
      test_load_read();
      test_write_waits();
      test_timeout();
      test_busy_events();
      test_back_to_back();
      test_stray_ack();
      vectors++;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_mem_data_port
